reconf_scheduler: RTL and testbench
===================================

Name: reconf_scheduler

Overview:
- Sequences partial/full reconfiguration loads from SPI flash via the ICAP flash loader.
- Arbitrates between two requesters, an explicit slot select and a "next slot" step from the video controller. Computes the flash address and length, and fires the loader trigger only at a frame boundary.
- Tracks loader busy with timeouts and reports the active slot.
- Replaces the free-running load-address counter in the top level.

Parameters:
- SLOT_BITS, 2, slot index width; number of slots = 2**SLOT_BITS.
- BASE_ADDR, 24'h00E000, flash address of slot 0.
- STRIDE_LOG2, 16, slot spacing in flash = 2**STRIDE_LOG2 bytes.
- SLOT_LEN, 24'h002D36, byte length driven on len for every slot.
- START_TIMEOUT, 16, max cycles from trigger to running rising.
- DONE_TIMEOUT, 24'h100000, max cycles running may stay high.

Ports:
- clk  in  1  pixel clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_next  in  1  pulse: load slot (cur_slot+1) mod 2**SLOT_BITS.
- req_sel  in  1  pulse: load slot req_slot.
- req_slot  in  SLOT_BITS  slot for req_sel, sampled when req_sel=1.
- frame_end  in  1  one-cycle pulse from the HDMI timing front end.
- running  in  1  loader busy, from icap_flash.
- trigger  out  1  one-cycle load start pulse to icap_flash.
- addr  out  24  flash address = BASE_ADDR + (target << STRIDE_LOG2), modulo 2**24.
- len  out  24  constant SLOT_LEN.
- cur_slot  out  SLOT_BITS  last successfully loaded slot.
- busy  out  1  high in any state except IDLE.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (synchronous, rst=1 at rising edge) sets:
  - state=IDLE, trigger=0, busy=0, error=0, cur_slot=0.
  - target=0, so addr=BASE_ADDR.
  - pending cleared, timeout counter=0.
- Request capture:
  - Runs every cycle, in any state.
  - req_sel has priority over req_next in the same cycle.
  - A single pending register holds {valid, is_sel, slot}. A later request overwrites an earlier one not yet started; the last request wins, and sel beats next when both arrive in one cycle.
  - A req_next target is resolved at acceptance, from cur_slot at that moment.
- Acceptance happens in IDLE with pending valid (or a request arriving that cycle):
  - target <= resolved slot, pending cleared, error cleared, state <= WAIT_FRAME.
  - addr updates the cycle after acceptance and stays stable until the next acceptance.
- WAIT_FRAME:
  - On frame_end=1, state <= FIRE.
  - A frame_end in the acceptance cycle itself is not used; the next frame_end is required.
- FIRE: trigger=1 for exactly this one cycle; counter <= 0; state <= WAIT_START.
- WAIT_START:
  - running=1 -> state <= WAIT_DONE, counter <= 0.
  - Else, counter reaching START_TIMEOUT-1 -> error <= 1, state <= IDLE, cur_slot unchanged.
- WAIT_DONE:
  - running=0 -> cur_slot <= target, state <= IDLE.
  - Else, counter reaching DONE_TIMEOUT-1 -> error <= 1, state <= IDLE.
- Requests arriving during WAIT_FRAME..WAIT_DONE are held pending. They are served from IDLE the cycle after return, so at most 1 IDLE cycle separates loads.
- Wrap: req_next with cur_slot = 2**SLOT_BITS-1 targets slot 0.
- Reset mid-operation (any state): returns to IDLE next cycle. trigger is never asserted in the reset cycle, and the pending request is discarded.
- Counters saturate and never wrap within a state.
- trigger is never high in two consecutive cycles.

Test Plan:
- Step request: rst; req_next pulse; frame_end at +5; running high 3 cycles after trigger for 100 cycles.
  -> trigger one cycle after frame_end; addr=24'h01E000, len=24'h002D36; cur_slot=1 after running falls; busy low next cycle.
- Wrap: four successive req_next loads.
  -> addr sequence 01E000, 02E000, 03E000, 00E000; final cur_slot=0.
- Priority: req_sel (req_slot=3) and req_next in the same IDLE cycle.
  -> target 3, addr=24'h03E000; no second load is queued.
- Start timeout: trigger with running held at 0.
  -> error=1 exactly START_TIMEOUT cycles after trigger; cur_slot unchanged; state IDLE.
  -> A following req_next clears error on acceptance.
- Queueing: req_sel slot 2, then req_sel slot 1 and req_next during WAIT_DONE.
  -> after the first load, the single next load targets slot 2's successor from the req_next (03E000), since the last request wins.
  -> Exactly two triggers in total.
- Reset mid-load: rst asserted in WAIT_START.
  -> all outputs at reset values the next cycle; no trigger until a new request and frame_end.

Source files
------------

// File: rtl/reconf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : reconf_scheduler
// Purpose  : Sequences reconfiguration loads from SPI flash through the ICAP
//            flash loader. Accepts an explicit slot select or a "next slot"
//            step, computes the flash address/length of the target slot and
//            fires the loader trigger only at a video frame boundary. Watches
//            the loader busy flag with start/done timeouts and reports the
//            last successfully loaded slot.
// Ports    : clk, rst          - pixel clock, synchronous active-high reset
//            req_next          - pulse: load slot (cur_slot + 1) mod slots
//            req_sel/req_slot  - pulse: load slot req_slot
//            frame_end         - one-cycle frame boundary pulse
//            running           - loader busy flag from icap_flash
//            trigger           - one-cycle load start pulse to icap_flash
//            addr, len         - flash address / byte length of the target
//            cur_slot          - last successfully loaded slot
//            busy              - scheduler not idle
//            error             - sticky timeout flag (cleared on next accept)
// Revision : 1.0 - initial release
// ============================================================================
module reconf_scheduler #(
    parameter int          SLOT_BITS     = 2,
    parameter logic [23:0] BASE_ADDR     = 24'h00E000,
    parameter int          STRIDE_LOG2   = 16,
    parameter logic [23:0] SLOT_LEN      = 24'h002D36,
    parameter int          START_TIMEOUT = 16,
    parameter logic [23:0] DONE_TIMEOUT  = 24'h100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_next,
    input  logic                 req_sel,
    input  logic [SLOT_BITS-1:0] req_slot,
    input  logic                 frame_end,
    input  logic                 running,
    output logic                 trigger,
    output logic [23:0]          addr,
    output logic [23:0]          len,
    output logic [SLOT_BITS-1:0] cur_slot,
    output logic                 busy,
    output logic                 error
);

    localparam logic [23:0] C_START_LAST = 24'(START_TIMEOUT - 1);
    localparam logic [23:0] C_DONE_LAST  = DONE_TIMEOUT - 24'd1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_FIRE       = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // Single-entry request holder: the most recent request wins.
    logic                   r_pend_valid;
    logic                   r_pend_sel;
    logic [SLOT_BITS-1:0]   r_pend_slot;

    logic [SLOT_BITS-1:0]   r_target;
    logic [SLOT_BITS-1:0]   r_cur_slot;
    logic                   r_error;
    logic [23:0]            r_cnt;

    logic                   w_req_any;
    logic [SLOT_BITS-1:0]   w_next_slot;
    logic [SLOT_BITS-1:0]   w_resolved;
    logic                   w_accept;
    logic                   w_fire;
    logic                   w_cnt_clr;
    logic                   w_timeout;
    logic                   w_commit;
    logic [23:0]            w_addr;

    // ------------------------------------------------------------------
    // Request resolution. A request arriving this cycle is newer than the
    // held one, so it overrides it; select beats next within a cycle. A
    // "next" request is resolved against cur_slot at acceptance time, so a
    // step queued during a load follows the slot that load just committed.
    // ------------------------------------------------------------------
    always_comb begin
        w_req_any   = req_sel | req_next | r_pend_valid;
        w_next_slot = r_cur_slot + SLOT_BITS'(1);
        if (req_sel) begin
            w_resolved = req_slot;
        end else if (req_next) begin
            w_resolved = w_next_slot;
        end else if (r_pend_sel) begin
            w_resolved = r_pend_slot;
        end else begin
            w_resolved = w_next_slot;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_timeout    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                // Only reached the cycle after acceptance, so a frame_end
                // coinciding with the request itself is never used.
                if (frame_end) begin
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                w_fire       = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (running) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_WAIT_DONE;
                end else if (r_cnt == C_START_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!running) begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == C_DONE_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: pending request, target, committed slot, error
    // flag and the shared timeout counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_pend_slot  <= '0;
            r_target     <= '0;
            r_cur_slot   <= '0;
            r_error      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b0;
                r_pend_sel   <= 1'b0;
                r_target     <= w_resolved;
                r_error      <= 1'b0;
            end else if (req_sel) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= 1'b1;
                r_pend_slot  <= req_slot;
            end else if (req_next) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= 1'b0;
            end

            // Timeouts only occur outside IDLE, so they never collide with
            // the error clear on acceptance.
            if (w_timeout) begin
                r_error <= 1'b1;
            end

            if (w_commit) begin
                r_cur_slot <= r_target;
            end

            // Saturating counter; it is cleared on entry to each timed state.
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 24'd1;
            end
        end
    end

    // Address is a pure function of the registered target, so it changes
    // only on the edge after acceptance.
    assign w_addr   = BASE_ADDR + (24'(r_target) << STRIDE_LOG2);

    // The FIRE state may coincide with a reset cycle; the loader must not
    // see a start pulse then.
    assign trigger  = w_fire & ~rst;
    assign addr     = w_addr;
    assign len      = SLOT_LEN;
    assign cur_slot = r_cur_slot;
    assign busy     = (r_state != S_IDLE);
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_reconf_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reconf_scheduler
// Purpose  : Self-checking bench for reconf_scheduler. Directed scenarios plus
//            randomized loads, checked against a slot-level reference model
//            (committed slot, slot->address arithmetic, trigger count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reconf_scheduler;

    localparam int          NSLOT    = 4;
    localparam int          START_TO = 16;
    localparam int          DONE_TO  = 400;
    localparam logic [23:0] BASE     = 24'h00E000;
    localparam logic [23:0] LEN      = 24'h002D36;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_next;
    logic        req_sel;
    logic [1:0]  req_slot;
    logic        frame_end;
    logic        running;
    logic        trigger;
    logic [23:0] addr;
    logic [23:0] len;
    logic [1:0]  cur_slot;
    logic        busy;
    logic        error;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_trig = 0;
    logic prev_trig = 1'b0;
    int   m_cur  = 0;     // model: last successfully loaded slot

    always #5 clk = ~clk;

    reconf_scheduler #(
        .SLOT_BITS    (2),
        .BASE_ADDR    (BASE),
        .STRIDE_LOG2  (16),
        .SLOT_LEN     (LEN),
        .START_TIMEOUT(START_TO),
        .DONE_TIMEOUT (24'(DONE_TO))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_next (req_next),
        .req_sel  (req_sel),
        .req_slot (req_slot),
        .frame_end(frame_end),
        .running  (running),
        .trigger  (trigger),
        .addr     (addr),
        .len      (len),
        .cur_slot (cur_slot),
        .busy     (busy),
        .error    (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slot s lives at BASE + s * 64 KiB, wrapped to the 24-bit flash space.
    function automatic logic [23:0] exp_addr(input int s);
        return 24'((int'(BASE) + s * 65536) % 16777216);
    endfunction

    // Trigger as seen by the loader (value held across the sampling edge).
    always begin
        @(negedge clk);
        #2;
        if (trigger === 1'b1) begin
            n_trig++;
            chk("trigger_not_back_to_back", 32'(prev_trig), 0);
        end
        prev_trig = trigger;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_trigger"},  32'(trigger),  0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_error"},    32'(error),    0);
        chk({tag, "_cur_slot"}, 32'(cur_slot), 0);
        chk({tag, "_addr"},     32'(addr),     32'(BASE));
        chk({tag, "_len"},      32'(len),      32'(LEN));
    endtask

    // Issue a request from IDLE and check acceptance one cycle later.
    task automatic request(input bit s, input bit n, input int slot, input bit fe, output int tgt);
        tgt       = s ? slot : (m_cur + 1) % NSLOT;
        req_sel   = s;
        req_next  = n;
        req_slot  = 2'(slot);
        frame_end = fe;
        @(negedge clk);
        req_sel   = 1'b0;
        req_next  = 1'b0;
        frame_end = 1'b0;
        chk("accept_busy",          32'(busy),    1);
        chk("accept_error_cleared", 32'(error),   0);
        chk("accept_no_trigger",    32'(trigger), 0);
        chk("accept_addr",          32'(addr),    32'(exp_addr(tgt)));
    endtask

    // From WAIT_FRAME: frame boundary after fe_gap cycles, loader starts
    // start_d cycles after trigger and stays busy run_len cycles. With inj,
    // a select(1) then a next request arrive while the loader is busy.
    task automatic run_load(input int tgt, input int fe_gap, input int start_d,
                            input int run_len, input bit inj);
        repeat (fe_gap - 1) begin
            @(negedge clk);
            chk("wait_frame_no_trigger", 32'(trigger), 0);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("trigger_after_frame_end", 32'(trigger), 1);
        chk("fire_addr", 32'(addr), 32'(exp_addr(tgt)));
        chk("fire_len",  32'(len),  32'(LEN));
        @(negedge clk);
        chk("trigger_single_cycle", 32'(trigger), 0);
        repeat (start_d - 1) @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < run_len; i++) begin
            @(negedge clk);
            if (inj) begin
                req_sel  = (i == 1);
                req_slot = 2'd1;
                req_next = (i == 3);
            end
        end
        chk("running_cur_slot_held", 32'(cur_slot), 32'(m_cur));
        chk("running_busy",          32'(busy),     1);
        running = 1'b0;
        @(negedge clk);
        chk("done_cur_slot",  32'(cur_slot), 32'(tgt));
        chk("done_busy_low",  32'(busy),     0);
        m_cur = tgt;
    endtask

    initial begin
        int t;
        int n0;
        rst = 1'b1; req_next = 1'b0; req_sel = 1'b0; req_slot = 2'd0;
        frame_end = 1'b0; running = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Step request: slot 0 -> 1, frame_end 5 cycles after the request.
        request(1'b0, 1'b1, 0, 1'b0, t);
        chk("step_addr", 32'(addr), 32'h01E000);
        run_load(t, 5, 3, 100, 1'b0);
        chk("step_cur_slot", 32'(cur_slot), 1);

        // Wrap: three more steps -> 2, 3, 0.
        for (int k = 0; k < 3; k++) begin
            request(1'b0, 1'b1, 0, 1'b0, t);
            run_load(t, 2 + k, 2, 10, 1'b0);
        end
        chk("wrap_final_slot", 32'(cur_slot), 0);

        // Priority: select(3) and next in the same cycle; nothing queued.
        request(1'b1, 1'b1, 3, 1'b0, t);
        chk("prio_addr", 32'(addr), 32'h03E000);
        run_load(t, 3, 1, 8, 1'b0);
        n0 = n_trig;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("prio_no_second_load", 32'(busy), 0);
            frame_end = (i % 4 == 0);
        end
        frame_end = 1'b0;
        @(negedge clk);
        chk("prio_trigger_count", 32'(n_trig - n0), 0);

        // Start timeout: running never rises. The error register is set
        // START_TIMEOUT edges after the edge that samples trigger.
        request(1'b0, 1'b1, 0, 1'b0, t);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("start_to_trigger", 32'(trigger), 1);
        for (int i = 1; i <= START_TO + 1; i++) begin
            @(negedge clk);
            if (i == START_TO) begin
                chk("start_to_not_yet", 32'(error), 0);
                chk("start_to_busy",    32'(busy),  1);
            end
        end
        chk("start_to_error",    32'(error),    1);
        chk("start_to_idle",     32'(busy),     0);
        chk("start_to_cur_slot", 32'(cur_slot), 32'(m_cur));
        request(1'b0, 1'b1, 0, 1'b0, t);   // clears error on acceptance
        run_load(t, 2, 4, 20, 1'b0);

        // Done timeout: running stays high past DONE_TO cycles.
        request(1'b1, 1'b0, 2, 1'b0, t);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("done_to_trigger", 32'(trigger), 1);
        repeat (2) @(negedge clk);
        running = 1'b1;
        for (int i = 1; i <= DONE_TO + 1; i++) begin
            @(negedge clk);
            if (i == DONE_TO) begin
                chk("done_to_not_yet", 32'(error), 0);
                chk("done_to_busy",    32'(busy),  1);
            end
        end
        chk("done_to_error",    32'(error),    1);
        chk("done_to_idle",     32'(busy),     0);
        chk("done_to_cur_slot", 32'(cur_slot), 32'(m_cur));
        running = 1'b0;
        @(negedge clk);

        // Queueing: select(1) then next during WAIT_DONE; last request wins.
        request(1'b1, 1'b0, 2, 1'b0, t);
        n0 = n_trig;
        run_load(t, 3, 2, 12, 1'b1);
        @(negedge clk);
        chk("queue_busy", 32'(busy), 1);
        chk("queue_addr", 32'(addr), 32'(exp_addr((m_cur + 1) % NSLOT)));
        chk("queue_addr_const", 32'(addr), 32'h03E000);
        run_load((m_cur + 1) % NSLOT, 2, 3, 15, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("queue_no_third_load", 32'(busy), 0);
            frame_end = (i % 3 == 0);
        end
        frame_end = 1'b0;
        @(negedge clk);
        chk("queue_two_triggers", 32'(n_trig - n0), 2);

        // Randomized loads against the slot model.
        for (int k = 0; k < 6; k++) begin
            bit s;
            bit n;
            s = 1'($urandom_range(0, 1));
            n = 1'($urandom_range(0, 1));
            if (!s && !n) n = 1'b1;
            request(s, n, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t);
            run_load(t, int'($urandom_range(1, 6)), int'($urandom_range(1, 10)),
                     int'($urandom_range(3, 60)), 1'b0);
        end

        // Reset in the FIRE cycle: trigger must be suppressed.
        request(1'b0, 1'b1, 0, 1'b0, t);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("pre_reset_trigger", 32'(trigger), 1);
        n0  = n_trig;
        rst = 1'b1;
        #1;
        chk("reset_masks_trigger", 32'(trigger), 0);
        @(negedge clk);
        chk_reset_state("reset_fire");
        rst   = 1'b0;
        m_cur = 0;
        @(negedge clk);
        chk("reset_fire_trigger_count", 32'(n_trig - n0), 0);

        // Reset in WAIT_START with a request pending: the request is dropped.
        request(1'b1, 1'b0, 2, 1'b0, t);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("ws_trigger", 32'(trigger), 1);
        @(negedge clk);
        req_sel  = 1'b1;
        req_slot = 2'd3;
        @(negedge clk);
        req_sel = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk_reset_state("reset_ws");
        rst = 1'b0;
        n0  = n_trig;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'(busy), 0);
            frame_end = (i % 5 == 0);
        end
        frame_end = 1'b0;
        @(negedge clk);
        chk("post_reset_no_trigger", 32'(n_trig - n0), 0);

        // Normal operation resumes after reset.
        request(1'b0, 1'b1, 0, 1'b0, t);
        run_load(t, 2, 2, 10, 1'b0);
        chk("final_cur_slot", 32'(cur_slot), 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
